sti_load_arbiter: RTL and testbench

STI_LOAD_ARBITER -- requirements
Module: sti_load_arbiter

---
 rtl/sti_pkg.sv | 27 ++
 rtl/rr_picker.sv | 30 +++
 rtl/sti_load_arbiter.sv | 126 ++++++++++++
 tb/tb_sti_load_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// sti_pkg: shared state encoding, length codes, cfg field offsets and
// length-to-bit-count helper for the serial transmitter load arbiter.
package sti_pkg;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARB   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;
   localparam logic [1:0] LEN_8  = 2'b00;
   localparam logic [1:0] LEN_16 = 2'b01;
   localparam logic [1:0] LEN_24 = 2'b10;
   localparam logic [1:0] LEN_32 = 2'b11;
   localparam int DATA_W   = 16;
   localparam int CFG_W    = 6;
   localparam int CFG_END  = 0;
   localparam int CFG_LOW  = 1;
   localparam int CFG_MSB  = 2;
   localparam int CFG_FILL = 3;
   localparam int CFG_LEN  = 4;
   // 00/01/10/11 -> 8/16/24/32 bits
   function automatic logic [5:0] len_bits(input logic [1:0] len);
      return {1'b0, len, 3'b000} + 6'd8;
   endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin selection of the first pending requester at or after ptr.
module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] grant,
   output logic [2:0]   idx,
   output logic         any
);
   logic [7:0] req8;
   logic [7:0] grant8;
   logic [2:0] j;
   assign req8  = 8'(req);
   assign grant = grant8[N-1:0];
   always_comb begin
      grant8 = '0;
      idx    = '0;
      any    = 1'b0;
      j      = '0;
      for (int k = 0; k < N; k++) begin
         j = 3'((int'(ptr) + k) % N);
         if (!any && req8[j]) begin
            any       = 1'b1;
            idx       = j;
            grant8[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sti_load_arbiter.sv
// sti_load_arbiter: round-robin arbiter feeding words to a serial transmitter.
// Define STI_ARB_WDOG_EN to add the so_valid stall watchdog driving err.
module sti_load_arbiter
   import sti_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GAP_CYC = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [16*NUM_REQ-1:0] req_data,
   input  logic [6*NUM_REQ-1:0]  req_cfg,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  load,
   output logic [15:0]           pi_data,
   output logic [1:0]            pi_length,
   output logic                  pi_fill,
   output logic                  pi_msb,
   output logic                  pi_low,
   output logic                  pi_end,
   input  logic                  so_valid,
   output logic                  busy,
   output logic [2:0]            grant_id,
   output logic                  done,
   output logic                  err
);
   localparam logic [2:0] LAST_REQ = 3'(NUM_REQ - 1);
   localparam logic [2:0] GAP_LAST = 3'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
   state_t              state, nxt;
   logic [2:0]          rr_ptr;
   logic [5:0]          bit_cnt;
   logic [2:0]          gap_cnt;
   logic [NUM_REQ-1:0]  pick_grant;
   logic [2:0]          pick_idx;
   logic                pick_any;
   logic [DATA_W-1:0]   data;
   logic [CFG_W-1:0]    cfg;
   logic                take;
   logic                shift_done;
   logic                wd_fire;
   rr_picker #(.N(NUM_REQ)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );
   always_comb begin
      data = '0;
      cfg  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_grant[i]) begin
            data = req_data[16*i +: 16];
            cfg  = req_cfg[6*i +: 6];
         end
      end
   end
   assign take       = state == ST_ARB && pick_any;
   assign shift_done = so_valid && (bit_cnt + 6'd1 == len_bits(pi_length));
   assign req_ready  = state == ST_ARB ? pick_grant : '0;
   assign busy       = state inside {ST_ARB, ST_LOAD, ST_SHIFT, ST_GAP};
   assign done       = state == ST_DONE;
`ifdef STI_ARB_WDOG_EN
   logic [3:0] wd_cnt;
   // fires on the 15th consecutive silent SHIFT cycle
   assign wd_fire = state == ST_SHIFT && !so_valid && wd_cnt == 4'd14;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else begin
         wd_cnt <= (state == ST_SHIFT && !so_valid) ? wd_cnt + 4'd1 : 4'd0;
         err    <= wd_fire;
      end
   end
`else
   assign wd_fire = 1'b0;
   assign err     = 1'b0;
`endif
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:  nxt = |req_valid ? ST_ARB : ST_IDLE;
         ST_ARB:   nxt = pick_any ? ST_LOAD : ST_IDLE;
         ST_LOAD:  nxt = ST_SHIFT;
         ST_SHIFT: nxt = shift_done ? (pi_end ? ST_DONE : (GAP_CYC == 0 ? ST_IDLE : ST_GAP))
                       : wd_fire ? ST_IDLE : ST_SHIFT;
         ST_GAP:   nxt = gap_cnt == GAP_LAST ? ST_IDLE : ST_GAP;
         default:  nxt = state;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         load      <= 1'b0;
         pi_data   <= '0;
         pi_length <= '0;
         pi_fill   <= 1'b0;
         pi_msb    <= 1'b0;
         pi_low    <= 1'b0;
         pi_end    <= 1'b0;
         grant_id  <= '0;
      end else begin
         state   <= nxt;
         load    <= take;
         gap_cnt <= state == ST_GAP ? gap_cnt + 3'd1 : 3'd0;
         if (take) begin
            pi_data   <= data;
            pi_length <= cfg[CFG_LEN +: 2];
            pi_fill   <= cfg[CFG_FILL];
            pi_msb    <= cfg[CFG_MSB];
            pi_low    <= cfg[CFG_LOW];
            pi_end    <= cfg[CFG_END];
            grant_id  <= pick_idx;
            rr_ptr    <= pick_idx == LAST_REQ ? 3'd0 : pick_idx + 3'd1;
            bit_cnt   <= '0;
         end else if (state == ST_SHIFT && so_valid) begin
            bit_cnt <= bit_cnt + 6'd1;
         end
      end
   end
endmodule

// File: tb/tb_sti_load_arbiter.sv
// tb_sti_load_arbiter: directed self-checking bench for sti_load_arbiter.
module tb_sti_load_arbiter;
   import sti_pkg::*;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [23:0] req_cfg;
   logic [3:0]  req_ready;
   logic        load, pi_fill, pi_msb, pi_low, pi_end, so_valid, busy, done, err;
   logic [15:0] pi_data;
   logic [1:0]  pi_length;
   logic [2:0]  grant_id;
   int checks = 0;
   int failures = 0;

   sti_load_arbiter #(.NUM_REQ(4), .GAP_CYC(1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_cfg(req_cfg), .req_ready(req_ready), .load(load), .pi_data(pi_data),
      .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
      .pi_end(pi_end), .so_valid(so_valid), .busy(busy), .grant_id(grant_id),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      so_valid  = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = '0;
      req_data  = '0;
      req_cfg   = '0;
      so_valid  = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      checks++;
      if ({load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, req_ready, busy, grant_id, done, err} !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs got load=%b pi_data=%h len=%b ready=%b busy=%b gid=%0d done=%b err=%b exp all 0",
                  load, pi_data, pi_length, req_ready, busy, grant_id, done, err);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      req_data[15:0] = 16'hA5C3;
      req_cfg[5:0]   = {LEN_16, 4'b1010};
      req_valid      = 4'b0001;
      tick();
      checks++;
      if ({req_ready, load, busy} !== {4'b0001, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL single_ready got ready=%b load=%b busy=%b exp 0001 0 1", req_ready, load, busy);
      end
      tick();
      req_valid = '0;
      checks++;
      if ({load, req_ready, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, grant_id} !==
          {1'b1, 4'b0000, 16'hA5C3, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL single_load got load=%b ready=%b data=%h len=%b f/m/l/e=%b%b%b%b gid=%0d exp 1 0000 a5c3 01 1010 0",
                  load, req_ready, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, grant_id);
      end
      tick();
      checks++;
      if ({load, busy} !== 2'b01) begin
         failures++;
         $display("FAIL single_shift_entry got load=%b busy=%b exp 0 1", load, busy);
      end
      so_valid = 1'b1;
      repeat (16) tick();
      so_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL single_gap got busy=%b exp 1", busy);
      end
      tick();
      checks++;
      if ({busy, done, err} !== 3'b000) begin
         failures++;
         $display("FAIL single_idle got busy=%b done=%b err=%b exp 000", busy, done, err);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req_data  = {16'hD333, 16'hD222, 16'hD111, 16'hD000};
      req_cfg   = '0;
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         checks++;
         if (req_ready !== 4'(1 << (g % 4))) begin
            failures++;
            $display("FAIL rr_ready[%0d] got %b exp %b", g, req_ready, 4'(1 << (g % 4)));
         end
         tick();
         checks++;
         if ({grant_id, pi_data, req_ready} !== {3'(g % 4), 16'hD000 + 16'(16'h111 * (g % 4)), 4'b0000}) begin
            failures++;
            $display("FAIL rr_grant[%0d] got gid=%0d data=%h ready=%b exp gid=%0d", g, grant_id, pi_data, req_ready, g % 4);
         end
         tick();
         so_valid = 1'b1;
         repeat (8) tick();
         so_valid = 1'b0;
         tick();
      end
      req_valid = '0;
   endtask

   task automatic test_long_word();
      do_reset();
      req_data[15:0] = 16'h1234;
      req_cfg[5:0]   = {LEN_32, 4'b0100};
      req_valid      = 4'b0001;
      tick();
      tick();
      req_valid = '0;
      tick();
      for (int i = 0; i < 35; i++) begin
         so_valid = !(i >= 10 && i < 13);
         tick();
         checks++;
         if (busy !== 1'b1 || (i < 34 && {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} !==
                                {16'h1234, 2'b11, 4'b0100})) begin
            failures++;
            $display("FAIL long_word[%0d] got busy=%b data=%h len=%b f/m/l/e=%b%b%b%b exp busy=1 1234 11 0100",
                     i, busy, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end);
         end
      end
      so_valid = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL long_word_exit got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_end_word();
      do_reset();
      req_data[15:0] = 16'hBEEF;
      req_cfg[5:0]   = {LEN_8, 4'b0001};
      req_valid      = 4'b0001;
      tick();
      tick();
      req_valid = '0;
      tick();
      so_valid = 1'b1;
      repeat (8) tick();
      so_valid = 1'b0;
      checks++;
      if ({done, busy} !== 2'b10) begin
         failures++;
         $display("FAIL end_done got done=%b busy=%b exp 1 0", done, busy);
      end
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({done, req_ready, load, busy} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL end_sticky[%0d] got done=%b ready=%b load=%b busy=%b exp 1 0000 0 0",
                     i, done, req_ready, load, busy);
         end
      end
      do_reset();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL end_cleared got done=%b exp 0", done);
      end
   endtask

   task automatic test_reset_mid_word();
      do_reset();
      req_data[31:16] = 16'h5A5A;
      req_cfg[11:6]   = {LEN_24, 4'b0000};
      req_valid       = 4'b0010;
      tick();
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL mid_ready got %b exp 0010", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      so_valid = 1'b1;
      repeat (10) tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, req_ready, busy, grant_id, done, err} !== 32'd0) begin
         failures++;
         $display("FAIL mid_reset got load=%b data=%h len=%b ready=%b busy=%b gid=%0d done=%b err=%b exp all 0",
                  load, pi_data, pi_length, req_ready, busy, grant_id, done, err);
      end
      so_valid  = 1'b0;
      reset     = 1'b0;
      req_valid = 4'b1111;
      tick();
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL mid_restart_ready got %b exp 0001", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (grant_id !== 3'd0) begin
         failures++;
         $display("FAIL mid_restart_gid got %0d exp 0", grant_id);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      req_cfg   = '0;
      req_valid = 4'b0001;
      tick();
      tick();
      req_valid = '0;
      tick();
      so_valid = 1'b0;
`ifdef STI_ARB_WDOG_EN
      for (int i = 0; i < 14; i++) begin
         tick();
         checks++;
         if ({busy, err} !== 2'b10) begin
            failures++;
            $display("FAIL wdog_wait[%0d] got busy=%b err=%b exp 1 0", i, busy, err);
         end
      end
      tick();
      checks++;
      if ({busy, err} !== 2'b01) begin
         failures++;
         $display("FAIL wdog_fire got busy=%b err=%b exp 0 1", busy, err);
      end
      req_valid = 4'b1111;
      tick();
      checks++;
      if ({err, req_ready} !== {1'b0, 4'b0010}) begin
         failures++;
         $display("FAIL wdog_after got err=%b ready=%b exp 0 0010", err, req_ready);
      end
      req_valid = '0;
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({busy, err} !== 2'b10) begin
            failures++;
            $display("FAIL nowdog_wait[%0d] got busy=%b err=%b exp 1 0", i, busy, err);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_long_word();
      test_end_word();
      test_reset_mid_word();
      test_watchdog();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
